// File: rtl/sd_cmd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sd_cmd_sched                                                    |
// | Function : Command-path scheduler in front of the SD command adapter.      |
// |            Arbitrates host / data-path requesters, drives sd_cmd/sd_arg,   |
// |            sequences CPSMEN against the adapter status flags and returns   |
// |            a one-cycle done pulse with an error code to the requester.     |
// | Options  : SD_CMD_RETRY_EN - reissue the command after a CRC failure.      |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module sd_cmd_sched #(
  parameter int START_TIMEOUT = 511,
  parameter int WDOG_CYCLES   = 4095,
  parameter int MAX_RETRY     = 2,
  parameter int RETRY_GAP     = 8
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic [5:0]  host_idx,
  input  logic [31:0] host_arg,
  input  logic [1:0]  host_rsp,
  output logic        host_done,
  output logic [1:0]  host_err,
  input  logic        dp_req,
  input  logic [5:0]  dp_idx,
  input  logic [31:0] dp_arg,
  input  logic [1:0]  dp_rsp,
  output logic        dp_done,
  output logic [1:0]  dp_err,
  output logic [31:0] sd_cmd,
  output logic [31:0] sd_arg,
  input  logic [31:0] sd_status,
  output logic        busy,
  output logic        grant_dp
);

  // Adapter status flag positions (shared SDIO status layout)
  localparam int c_ccrcfail_bit = 0;
  localparam int c_ctimeout_bit = 2;
  localparam int c_cmdrend_bit  = 6;
  localparam int c_cmdsent_bit  = 7;
  localparam int c_cmdact_bit   = 11;

  // Error codes returned with done
  localparam logic [1:0] c_err_ok   = 2'b00;
  localparam logic [1:0] c_err_crc  = 2'b01;
  localparam logic [1:0] c_err_rto  = 2'b10;
  localparam logic [1:0] c_err_tout = 2'b11;

  // One shared counter serves the start timeout, the watchdog and the retry gap
  localparam int c_cnt_max_a = (WDOG_CYCLES > START_TIMEOUT) ? WDOG_CYCLES : START_TIMEOUT;
  localparam int c_cnt_max   = (c_cnt_max_a > RETRY_GAP) ? c_cnt_max_a : RETRY_GAP;
  localparam int c_cnt_w     = $clog2(c_cnt_max + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_ACTIVE = 3'd2,
    S_DONE   = 3'd3
`ifdef SD_CMD_RETRY_EN
    ,
    S_RETRY  = 3'd4
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [5:0]           idx_q, idx_d;
  logic [1:0]           rsp_q, rsp_d;
  logic [1:0]           err_q, err_d;
  logic [31:0]          sd_cmd_q, sd_cmd_d;
  logic [31:0]          sd_arg_q, sd_arg_d;
  logic                 host_done_q, host_done_d;
  logic                 dp_done_q, dp_done_d;
  logic [1:0]           host_err_q, host_err_d;
  logic [1:0]           dp_err_q, dp_err_d;
  logic                 busy_q, busy_d;
  logic                 grant_dp_q, grant_dp_d;

`ifdef SD_CMD_RETRY_EN
  localparam int c_retry_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [c_retry_w-1:0] retry_q, retry_d;
`else
  // Retry parameters only matter when reissue is built in
  localparam int c_unused_retry_params = MAX_RETRY + RETRY_GAP;
`endif

  // Status decode
  logic w_cmdact;
  logic w_crc;
  logic w_cto;
  logic w_ok;
  logic w_complete;
  assign w_cmdact   = sd_status[c_cmdact_bit];
  assign w_crc      = sd_status[c_ccrcfail_bit];
  assign w_cto      = sd_status[c_ctimeout_bit];
  assign w_ok       = sd_status[c_cmdrend_bit] | sd_status[c_cmdsent_bit];
  assign w_complete = !w_cmdact && (w_crc || w_cto || w_ok);

  logic unused_status;
  assign unused_status = ^{sd_status[31:12], sd_status[10:8], sd_status[5:3], sd_status[1]};

  // Arbitration: a tie goes to whichever requester was not granted last
  logic        w_any_req;
  logic        w_pick_dp;
  logic [5:0]  w_sel_idx;
  logic [1:0]  w_sel_rsp;
  logic [31:0] w_sel_arg;
  assign w_any_req = host_req | dp_req;
  assign w_pick_dp = dp_req && (!host_req || !grant_dp_q);
  assign w_sel_idx = w_pick_dp ? dp_idx : host_idx;
  assign w_sel_rsp = w_pick_dp ? dp_rsp : host_rsp;
  assign w_sel_arg = w_pick_dp ? dp_arg : host_arg;

  function automatic logic [31:0] cmd_word(input logic [5:0] idx, input logic [1:0] rsp,
                                           input logic en);
    // [10] CPSMEN, [9] WAITPEND=0, [8]=0, [7] LONGRESP, [6] WAITRESP, [5:0] index
    cmd_word = {21'd0, en, 2'b00, rsp, idx};
  endfunction

  // Next-state and next-output computation for the command sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rsp_d       = rsp_q;
    err_d       = err_q;
    sd_cmd_d    = sd_cmd_q;
    sd_arg_d    = sd_arg_q;
    grant_dp_d  = grant_dp_q;
    host_done_d = 1'b0;
    dp_done_d   = 1'b0;
    host_err_d  = 2'b00;
    dp_err_d    = 2'b00;
`ifdef SD_CMD_RETRY_EN
    retry_d     = retry_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef SD_CMD_RETRY_EN
        retry_d = '0;
`endif
        // A done pulse in flight means the requester has not had a chance to drop req
        if (!(host_done_q || dp_done_q) && w_any_req) begin
          grant_dp_d = w_pick_dp;
          idx_d      = w_sel_idx;
          rsp_d      = w_sel_rsp;
          sd_arg_d   = w_sel_arg;
          sd_cmd_d   = cmd_word(w_sel_idx, w_sel_rsp, 1'b1);
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // CMDACT is checked first so it wins a tie with the timeout
        if (w_cmdact) begin
          sd_cmd_d = cmd_word(idx_q, rsp_q, 1'b0);
          cnt_d    = '0;
          state_d  = S_ACTIVE;
        end else if (cnt_q == c_cnt_w'(START_TIMEOUT)) begin
          sd_cmd_d = '0;
          err_d    = c_err_tout;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end

      S_ACTIVE: begin
        if (w_complete) begin
          if (w_crc) begin
`ifdef SD_CMD_RETRY_EN
            if (retry_q < c_retry_w'(MAX_RETRY)) begin
              sd_cmd_d = '0;
              cnt_d    = '0;
              state_d  = S_RETRY;
            end else begin
              err_d   = c_err_crc;
              state_d = S_DONE;
            end
`else
            err_d   = c_err_crc;
            state_d = S_DONE;
`endif
          end else if (w_cto) begin
            err_d   = c_err_rto;
            state_d = S_DONE;
          end else begin
            err_d   = c_err_ok;
            state_d = S_DONE;
          end
        end else if (cnt_q == c_cnt_w'(WDOG_CYCLES)) begin
          err_d   = c_err_tout;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end

      S_DONE: begin
        sd_cmd_d = '0;
        if (grant_dp_q) begin
          dp_done_d = 1'b1;
          dp_err_d  = err_q;
        end else begin
          host_done_d = 1'b1;
          host_err_d  = err_q;
        end
        state_d = S_IDLE;
      end

`ifdef SD_CMD_RETRY_EN
      S_RETRY: begin
        // Reissue the latched command after the idle gap; the grant is kept
        if (cnt_q == c_cnt_w'(RETRY_GAP - 1)) begin
          retry_d  = retry_q + c_retry_w'(1);
          sd_cmd_d = cmd_word(idx_q, rsp_q, 1'b1);
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
`endif

      default: begin
        sd_cmd_d = '0;
        state_d  = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rsp_q       <= '0;
      err_q       <= '0;
      sd_cmd_q    <= '0;
      sd_arg_q    <= '0;
      host_done_q <= 1'b0;
      dp_done_q   <= 1'b0;
      host_err_q  <= '0;
      dp_err_q    <= '0;
      busy_q      <= 1'b0;
      grant_dp_q  <= 1'b0;
`ifdef SD_CMD_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rsp_q       <= rsp_d;
      err_q       <= err_d;
      sd_cmd_q    <= sd_cmd_d;
      sd_arg_q    <= sd_arg_d;
      host_done_q <= host_done_d;
      dp_done_q   <= dp_done_d;
      host_err_q  <= host_err_d;
      dp_err_q    <= dp_err_d;
      busy_q      <= busy_d;
      grant_dp_q  <= grant_dp_d;
`ifdef SD_CMD_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign sd_cmd    = sd_cmd_q;
  assign sd_arg    = sd_arg_q;
  assign host_done = host_done_q;
  assign host_err  = host_err_q;
  assign dp_done   = dp_done_q;
  assign dp_err    = dp_err_q;
  assign busy      = busy_q;
  assign grant_dp  = grant_dp_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sd_cmd_sched                                                 |
// | Function : Self-checking bench for sd_cmd_sched with an SD adapter model   |
// |            and a transaction-level reference of grant, word and error.     |
// | Options  : SD_CMD_RETRY_EN - expected attempt count on CRC failures.       |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_sd_cmd_sched;

  localparam int START_TIMEOUT = 511;
  localparam int WDOG_CYCLES   = 4095;
  localparam int MAX_RETRY     = 2;
  localparam int RETRY_GAP     = 8;

`ifdef SD_CMD_RETRY_EN
  localparam int c_crc_attempts = MAX_RETRY + 1;
`else
  localparam int c_crc_attempts = 1;
`endif

  localparam int c_ccrcfail = 0;
  localparam int c_ctimeout = 2;
  localparam int c_cmdrend  = 6;
  localparam int c_cmdsent  = 7;
  localparam int c_cmdact   = 11;

  // Adapter outcome per command
  localparam int c_oc_rend  = 0;
  localparam int c_oc_sent  = 1;
  localparam int c_oc_cto   = 2;
  localparam int c_oc_crc   = 3;
  localparam int c_oc_noact = 4;
  localparam int c_oc_hang  = 5;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic        host_req, dp_req;
  logic [5:0]  host_idx, dp_idx;
  logic [31:0] host_arg, dp_arg;
  logic [1:0]  host_rsp, dp_rsp;
  logic        host_done, dp_done;
  logic [1:0]  host_err, dp_err;
  logic [31:0] sd_cmd, sd_arg, sd_status;
  logic        busy, grant_dp;

  int checks = 0;
  int errors = 0;

  // Reference model state: last grant and the pending values per requester
  bit          last_dp = 1'b0;
  logic [5:0]  m_hidx, m_didx;
  logic [31:0] m_harg, m_darg;
  logic [1:0]  m_hrsp, m_drsp;

  sd_cmd_sched #(
    .START_TIMEOUT (START_TIMEOUT),
    .WDOG_CYCLES   (WDOG_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .RETRY_GAP     (RETRY_GAP)
  ) dut (
    .sd_clk    (sd_clk),
    .rst       (rst),
    .host_req  (host_req),
    .host_idx  (host_idx),
    .host_arg  (host_arg),
    .host_rsp  (host_rsp),
    .host_done (host_done),
    .host_err  (host_err),
    .dp_req    (dp_req),
    .dp_idx    (dp_idx),
    .dp_arg    (dp_arg),
    .dp_rsp    (dp_rsp),
    .dp_done   (dp_done),
    .dp_err    (dp_err),
    .sd_cmd    (sd_cmd),
    .sd_arg    (sd_arg),
    .sd_status (sd_status),
    .busy      (busy),
    .grant_dp  (grant_dp)
  );

  always #5 sd_clk = ~sd_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected adapter command word with CPSMEN set
  function automatic logic [31:0] exp_cmd(input logic [5:0] idx, input logic [1:0] rsp);
    int w;
    w = int'(idx) + (rsp[0] ? 64 : 0) + (rsp[1] ? 128 : 0) + 1024;
    return 32'(w);
  endfunction

  // One granted command from request to done; caller is positioned on a negedge.
  task automatic run_txn(input bit new_h, input bit new_d,
                         input logic [5:0] hi, input logic [31:0] ha, input logic [1:0] hr,
                         input logic [5:0] di, input logic [31:0] da, input logic [1:0] dr,
                         input int dly, input int alen, input int outc);
    bit          exp_dp, prev_cps, done_dp;
    logic [31:0] exp_word, exp_arg, fin_flags;
    logic [1:0]  exp_err, done_err;
    int          exp_att, attempts, ndone, zero_run, cps_len;
    int          cps0, act_cyc, cmpl_cyc, done_cyc, acnt, aphase;

    if (new_h && !host_req) begin
      m_hidx = hi; m_harg = ha; m_hrsp = hr;
      host_idx = hi; host_arg = ha; host_rsp = hr; host_req = 1'b1;
    end
    if (new_d && !dp_req) begin
      m_didx = di; m_darg = da; m_drsp = dr;
      dp_idx = di; dp_arg = da; dp_rsp = dr; dp_req = 1'b1;
    end
    exp_dp   = (host_req && dp_req) ? !last_dp : dp_req;
    last_dp  = exp_dp;
    exp_word = exp_dp ? exp_cmd(m_didx, m_drsp) : exp_cmd(m_hidx, m_hrsp);
    exp_arg  = exp_dp ? m_darg : m_harg;

    fin_flags = '0;
    exp_att   = 1;
    case (outc)
      c_oc_rend: begin fin_flags[c_cmdrend] = 1'b1; exp_err = 2'b00; end
      c_oc_sent: begin fin_flags[c_cmdsent] = 1'b1; exp_err = 2'b00; end
      c_oc_cto: begin
        fin_flags[c_ctimeout] = 1'b1;
        fin_flags[c_cmdsent]  = 1'($urandom_range(0, 1));
        exp_err = 2'b10;
      end
      c_oc_crc: begin
        fin_flags[c_ccrcfail] = 1'b1;
        fin_flags[c_ctimeout] = 1'($urandom_range(0, 1));
        fin_flags[c_cmdrend]  = 1'($urandom_range(0, 1));
        exp_err = 2'b01;
        exp_att = c_crc_attempts;
      end
      default: exp_err = 2'b11;
    endcase

    prev_cps = 1'b0; done_dp = 1'b0; done_err = 2'b00;
    attempts = 0; ndone = 0; zero_run = 0; cps_len = 0;
    cps0 = 0; act_cyc = -10; cmpl_cyc = 0; done_cyc = 0; acnt = 0; aphase = 0;

    for (int cyc = 1; cyc <= 6000; cyc++) begin
      @(negedge sd_clk);
      if (sd_cmd[10] && !prev_cps) begin
        attempts++;
        check("cmd_word", sd_cmd, exp_word);
        check("cmd_arg", sd_arg, exp_arg);
        check("grant_dp", 32'(grant_dp), 32'(exp_dp));
        check("busy_issue", 32'(busy), 32'd1);
        if (attempts > 1) check("retry_gap", 32'(zero_run >= RETRY_GAP), 32'd1);
        // The granted requester is free to change its inputs now
        if (exp_dp) begin
          dp_idx = 6'($urandom); dp_arg = $urandom; dp_rsp = 2'($urandom);
        end else begin
          host_idx = 6'($urandom); host_arg = $urandom; host_rsp = 2'($urandom);
        end
        cps0 = cyc; cps_len = 0; aphase = 1; acnt = dly;
      end
      prev_cps = sd_cmd[10];
      if (sd_cmd[10]) cps_len++;
      zero_run = (sd_cmd == 32'd0) ? zero_run + 1 : 0;
      if (aphase == 2 && cyc == act_cyc + 1) begin
        check("cpsmen_len", 32'(cps_len), 32'(dly + 1));
        check("cmd_held", sd_cmd, exp_word & ~32'h400);
      end
      if (host_done || dp_done) begin
        ndone++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          done_dp  = dp_done;
          done_err = dp_done ? dp_err : host_err;
          check("cmd_cleared", sd_cmd, 32'd0);
        end
        if (dp_done) dp_req = 1'b0;
        if (host_done) host_req = 1'b0;
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        check("busy_after_done", 32'(busy), 32'd0);
        break;
      end
      // Adapter model: CMDACT after dly cycles (clears sticky flags), then completion
      if (aphase == 1) begin
        if (outc != c_oc_noact) begin
          if (acnt == 0) begin
            sd_status = 32'(1) << c_cmdact;
            act_cyc = cyc; acnt = alen; aphase = 2;
          end else acnt--;
        end
      end else if (aphase == 2) begin
        if (outc != c_oc_hang) begin
          if (acnt == 0) begin
            sd_status = fin_flags;
            cmpl_cyc = cyc; aphase = 0;
          end else acnt--;
        end
      end
    end

    if (done_cyc == 0) begin
      check("done_seen", 32'd0, 32'd1);
    end else begin
      check("done_who", 32'(done_dp), 32'(exp_dp));
      check("done_err", 32'(done_err), 32'(exp_err));
      check("done_pulses", 32'(ndone), 32'd1);
      check("attempts", 32'(attempts), 32'(exp_att));
      if (outc == c_oc_noact)
        check("start_tout_lat", 32'(done_cyc - cps0), 32'(START_TIMEOUT + 2));
      else if (outc == c_oc_hang)
        check("wdog_lat", 32'(done_cyc - (act_cyc + 1)), 32'(WDOG_CYCLES + 2));
      else
        check("done_lat", 32'(done_cyc - cmpl_cyc), 32'd2);
    end
  endtask

  // Reset while a data-path command is in ACTIVE; no requests pending on entry.
  task automatic run_reset_mid();
    int n;
    dp_idx = 6'd12; dp_arg = 32'h55; dp_rsp = 2'b01; dp_req = 1'b1;
    n = 0;
    do begin
      @(negedge sd_clk);
      n++;
    end while (!sd_cmd[10] && n < 20);
    sd_status = 32'(1) << c_cmdact;
    @(negedge sd_clk);
    @(negedge sd_clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_grant", 32'(grant_dp), 32'd1);
    rst = 1'b1; dp_req = 1'b0;
    @(negedge sd_clk);
    check("rst_sd_cmd", sd_cmd, 32'd0);
    check("rst_sd_arg", sd_arg, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_dp), 32'd0);
    rst = 1'b0; sd_status = '0;
    n = 0;
    repeat (4) begin
      if (host_done || dp_done) n++;
      @(negedge sd_clk);
    end
    check("no_done_after_rst", 32'(n), 32'd0);
    last_dp = 1'b0;
  endtask

  initial begin
    bit nh, nd;
    rst = 1'b1;
    host_req = 1'b0; host_idx = '0; host_arg = '0; host_rsp = '0;
    dp_req = 1'b0; dp_idx = '0; dp_arg = '0; dp_rsp = '0;
    sd_status = '0;
    repeat (3) @(negedge sd_clk);
    check("reset_sd_cmd", sd_cmd, 32'd0);
    check("reset_sd_arg", sd_arg, 32'd0);
    check("reset_outs", 32'({host_done, dp_done, host_err, dp_err, busy, grant_dp}), 32'd0);
    rst = 1'b0;
    @(negedge sd_clk);

    // Basic host command: CMD8, arg 0x1AA, short response, CMDACT after 4 cycles
    run_txn(1, 0, 6'd8, 32'h1AA, 2'b01, 6'd0, 32'd0, 2'b00, 4, 2, c_oc_rend);
    // Simultaneous requests: data path first, then host
    run_txn(1, 1, 6'd17, 32'h1000, 2'b01, 6'd12, 32'd0, 2'b01, 1, 1, c_oc_rend);
    run_txn(0, 0, 6'd0, 32'd0, 2'b00, 6'd0, 32'd0, 2'b00, 2, 0, c_oc_sent);
    // Adapter never starts
    run_txn(1, 0, 6'd2, 32'h0, 2'b11, 6'd0, 32'd0, 2'b00, 0, 0, c_oc_noact);
    // Response timeout and no-response command
    run_txn(1, 0, 6'd55, 32'hABCD0000, 2'b01, 6'd0, 32'd0, 2'b00, 2, 3, c_oc_cto);
    run_txn(0, 1, 6'd0, 32'd0, 2'b00, 6'd0, 32'd0, 2'b00, 0, 0, c_oc_sent);
    // CRC failure on every attempt
    run_txn(1, 0, 6'd13, 32'h00010000, 2'b01, 6'd0, 32'd0, 2'b00, 3, 2, c_oc_crc);
    // Completion never arrives
    run_txn(0, 1, 6'd0, 32'd0, 2'b00, 6'd7, 32'h12345678, 2'b01, 1, 0, c_oc_hang);
    // Reset mid-command, then a tie must go to the data path again
    run_reset_mid();
    run_txn(1, 1, 6'd9, 32'h9, 2'b10, 6'd12, 32'hC, 2'b01, 0, 1, c_oc_rend);
    run_txn(0, 0, 6'd0, 32'd0, 2'b00, 6'd0, 32'd0, 2'b00, 1, 1, c_oc_rend);

    // Randomized traffic
    repeat (24) begin
      nh = 1'($urandom_range(0, 1));
      nd = 1'($urandom_range(0, 1));
      if (!nh && !nd && !host_req && !dp_req) nh = 1'b1;
      run_txn(nh, nd, 6'($urandom), $urandom, 2'($urandom),
              6'($urandom), $urandom, 2'($urandom),
              $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
